// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Round-robin sequencer for the LC-3 memory unit (MAR/MDR/RAM).
//               Serves CPU and loader word read/write requests one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int READ_LAT = 1,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [DATA_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] MDROut,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              ldMAR,
    output logic              ldMDR,
    output logic              memWE,
    output logic              selMDR,
    output logic              busy
);

    localparam int unsigned        c_CNT_W    = 3;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_MAR   = 3'd1,
        S_LD_MDR_W = 3'd2,
        S_WRITE    = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_LD_MDR_R = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_we;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_sel_ldr;
    logic                r_rr_ldr;

    logic                w_any_req;
    logic                w_grant_ldr;
    logic                w_take;

    // On a tie the requester that was not granted last wins.
    assign w_any_req   = cpu_req | ldr_req;
    assign w_grant_ldr = ldr_req & (~cpu_req | ~r_rr_ldr);
    assign w_take      = (r_state == S_IDLE) & w_any_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request fields are captured only at grant, so later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel_ldr <= 1'b0;
            r_rr_ldr  <= 1'b1;
        end else if (w_take) begin
            r_sel_ldr <= w_grant_ldr;
            r_rr_ldr  <= w_grant_ldr;
            r_we      <= w_grant_ldr ? ldr_we    : cpu_we;
            r_addr    <= w_grant_ldr ? ldr_addr  : cpu_addr;
            r_wdata   <= w_grant_ldr ? ldr_wdata : cpu_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_LD_MAR;
                end
            end
            S_LD_MAR: begin
                if (r_we) begin
                    w_state_nxt = S_LD_MDR_W;
                end else begin
                    w_state_nxt = S_RD_WAIT;
                    w_cnt_nxt   = c_CNT_INIT;
                end
            end
            S_LD_MDR_W: w_state_nxt = S_WRITE;
            S_WRITE:    w_state_nxt = S_DONE;
            S_RD_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = S_LD_MDR_R;
                end
            end
            S_LD_MDR_R: w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Moore decode: reset clears r_state asynchronously, so every control drops at once.
    always_comb begin
        bus_out = '0;
        bus_oe  = 1'b0;
        ldMAR   = 1'b0;
        ldMDR   = 1'b0;
        memWE   = 1'b0;
        selMDR  = 1'b0;
        cpu_ack = 1'b0;
        ldr_ack = 1'b0;
        rdata   = '0;
        case (r_state)
            S_LD_MAR: begin
                bus_oe  = 1'b1;
                bus_out = r_addr;
                ldMAR   = 1'b1;
            end
            S_LD_MDR_W: begin
                bus_oe  = 1'b1;
                bus_out = r_wdata;
                ldMDR   = 1'b1;
            end
            S_WRITE: begin
                memWE = 1'b1;
            end
            S_LD_MDR_R: begin
                ldMDR  = 1'b1;
                selMDR = 1'b1;
            end
            S_DONE: begin
                cpu_ack = ~r_sel_ldr;
                ldr_ack = r_sel_ldr;
                rdata   = MDROut;
            end
            default: begin
                bus_oe = 1'b0;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed bench for mem_access_ctrl with a MAR/MDR/RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        cpu_ack, ldr_ack, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy;
    logic [15:0] rdata, bus_out, mdr, mar;
    logic [15:0] ram [0:65535];

    logic        cpu3_req, cpu3_we, ldr3_req, ldr3_we;
    logic [15:0] cpu3_addr, cpu3_wdata, ldr3_addr, ldr3_wdata;
    logic        cpu3_ack, ldr3_ack, bus_oe3, ldMAR3, ldMDR3, memWE3, selMDR3, busy3;
    logic [15:0] rdata3, bus_out3, mdr3, mar3;

    int n_chk = 0;
    int n_pass = 0;
    int viol = 0;
    int we_pulses = 0;

    logic        who;
    logic [15:0] dat;
    int          ncyc;

    always #5 clk = ~clk;

    mem_access_ctrl #(.READ_LAT(1), .DATA_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack),
        .rdata(rdata), .MDROut(mdr), .bus_out(bus_out), .bus_oe(bus_oe),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .memWE(memWE), .selMDR(selMDR), .busy(busy)
    );

    mem_access_ctrl #(.READ_LAT(3), .DATA_W(16)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu3_req), .cpu_we(cpu3_we), .cpu_addr(cpu3_addr), .cpu_wdata(cpu3_wdata),
        .cpu_ack(cpu3_ack),
        .ldr_req(ldr3_req), .ldr_we(ldr3_we), .ldr_addr(ldr3_addr), .ldr_wdata(ldr3_wdata),
        .ldr_ack(ldr3_ack),
        .rdata(rdata3), .MDROut(mdr3), .bus_out(bus_out3), .bus_oe(bus_oe3),
        .ldMAR(ldMAR3), .ldMDR(ldMDR3), .memWE(memWE3), .selMDR(selMDR3), .busy(busy3)
    );

    // Memory unit model: MAR/MDR registers and a combinational-read RAM.
    always @(posedge clk) begin
        if (reset) ram[16'h4000] <= 16'h0AAA;
        if (ldMAR) mar <= bus_out;
        if (ldMDR) mdr <= selMDR ? ram[mar] : bus_out;
        if (memWE) ram[mar] <= mdr;
    end

    always @(posedge clk) begin
        if (ldMAR3) mar3 <= bus_out3;
        if (ldMDR3) mdr3 <= selMDR3 ? ((mar3 == 16'h2000) ? 16'hC0DE : 16'h0000) : bus_out3;
    end

    always @(negedge clk) begin
        if ($countones({ldMAR, ldMDR, memWE}) > 1 || (selMDR && !ldMDR) ||
            (bus_oe && !(ldMAR || (ldMDR && !selMDR))))
            viol <= viol + 1;
        if (memWE) we_pulses <= we_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for an ack on the READ_LAT=1 instance; ncyc=0 means none came.
    task automatic wait_ack(output logic w, output logic [15:0] d, output int n);
        w = 1'b0;
        d = '0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (cpu_ack || ldr_ack) begin
                chk("ack_excl", {31'd0, cpu_ack & ldr_ack}, 32'd0);
                w = ldr_ack;
                d = rdata;
                n = i;
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        cpu3_req = 0; cpu3_we = 0; cpu3_addr = '0; cpu3_wdata = '0;
        ldr3_req = 0; ldr3_we = 0; ldr3_addr = '0; ldr3_wdata = '0;
        tick();
        tick();
        chk("rst_ctrl", {24'd0, cpu_ack, ldr_ack, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'd0);
        chk("rst_bus", {16'd0, bus_out}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: CPU write 0x3000 <- 0xBEEF ({bus_oe,ldMAR,ldMDR,memWE,selMDR,busy})
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 16'hBEEF;
        tick();
        chk("t1_c1_ctrl", {26'd0, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'b110001);
        chk("t1_c1_bus", {16'd0, bus_out}, 32'h3000);
        tick();
        chk("t1_c2_ctrl", {26'd0, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'b101001);
        chk("t1_c2_bus", {16'd0, bus_out}, 32'hBEEF);
        tick();
        chk("t1_c3_ctrl", {26'd0, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'b000101);
        chk("t1_c3_ack", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        tick();
        chk("t1_c4_ack", {30'd0, cpu_ack, ldr_ack}, 32'b10);
        cpu_req = 0;
        tick();
        chk("t1_idle", {30'd0, cpu_ack, busy}, 32'd0);
        chk("t1_ram", {16'd0, ram[16'h3000]}, 32'hBEEF);

        // Test 2: CPU read 0x3000
        cpu_req = 1; cpu_we = 0;
        tick();
        chk("t2_c1_ctrl", {26'd0, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'b110001);
        tick();
        chk("t2_c2_ctrl", {26'd0, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'b000001);
        tick();
        chk("t2_c3_ctrl", {26'd0, bus_oe, ldMAR, ldMDR, memWE, selMDR, busy}, 32'b001011);
        tick();
        chk("t2_c4_ack", {30'd0, cpu_ack, ldr_ack}, 32'b10);
        chk("t2_rdata", {16'd0, rdata}, 32'hBEEF);
        cpu_req = 0;
        tick();

        // Test 6: inputs change after grant; latched values must be used
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3100; cpu_wdata = 16'h5555;
        tick();
        cpu_addr = 16'hFFFF; cpu_wdata = 16'hFFFF;
        tick();
        chk("t6_bus_wdata", {16'd0, bus_out}, 32'h5555);
        tick();
        tick();
        chk("t6_ack", {30'd0, cpu_ack, ldr_ack}, 32'b10);
        cpu_req = 0;
        tick();
        chk("t6_ram", {16'd0, ram[16'h3100]}, 32'h5555);
        chk("t6_ffff_untouched", {31'd0, ram[16'hFFFF] == 16'hFFFF}, 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Test 3: simultaneous requests after reset, CPU keeps requesting
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h4000; ldr_wdata = 16'h1234;
        wait_ack(who, dat, ncyc);
        chk("t3a_who", {31'd0, who}, 32'd0);
        chk("t3a_rdata", {16'd0, dat}, 32'h0AAA);
        chk("t3a_cyc", ncyc, 32'd4);
        wait_ack(who, dat, ncyc);
        chk("t3b_who", {31'd0, who}, 32'd1);
        chk("t3b_cyc", ncyc, 32'd5);
        ldr_req = 0;
        wait_ack(who, dat, ncyc);
        chk("t3c_who", {31'd0, who}, 32'd0);
        chk("t3c_rdata", {16'd0, dat}, 32'h1234);
        chk("t3c_cyc", ncyc, 32'd5);
        cpu_req = 0;
        tick();

        // Test 4: reset asserted while in WRITE
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h5000; cpu_wdata = 16'h7777;
        tick();
        tick();
        tick();
        chk("t4_in_write", {31'd0, memWE}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_drop", {28'd0, memWE, bus_oe, busy, cpu_ack}, 32'd0);
        cpu_req = 0;
        tick();
        tick();
        chk("t4_no_ack", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t4_no_write", {31'd0, ram[16'h5000] == 16'h7777}, 32'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        wait_ack(who, dat, ncyc);
        chk("t4_read_who", {31'd0, who}, 32'd0);
        chk("t4_read_rdata", {16'd0, dat}, 32'hBEEF);
        chk("t4_read_cyc", ncyc, 32'd4);
        cpu_req = 0;
        tick();

        // Test 5: READ_LAT=3 instance, ack six cycles after grant
        cpu3_req = 1; cpu3_we = 0; cpu3_addr = 16'h2000;
        tick();
        chk("t5_c1", {28'd0, ldMAR3, ldMDR3, memWE3, busy3}, 32'b1001);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_wait", {27'd0, bus_oe3, ldMAR3, ldMDR3, memWE3, busy3}, 32'b00001);
        end
        tick();
        chk("t5_ldmdr", {30'd0, ldMDR3, selMDR3}, 32'b11);
        tick();
        chk("t5_ack", {30'd0, cpu3_ack, ldr3_ack}, 32'b10);
        chk("t5_rdata", {16'd0, rdata3}, 32'hC0DE);
        cpu3_req = 0;
        tick();
        chk("t5_idle", {30'd0, cpu3_ack, busy3}, 32'd0);

        chk("ctrl_onehot_viol", viol, 32'd0);
        chk("memwe_pulses", we_pulses, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
